// File: rtl/data_mem_stage.sv
// MEM pipeline stage: byte-lane data memory with sized stores and sign/zero-extended loads.
// Define DMEM_MISALIGN_TRAP_EN to suppress and flag misaligned accesses instead of forcing alignment.
module data_mem_stage #(
  parameter int ADDR_W = 8
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Stall,
  input  logic              MemRead_EX,
  input  logic              MemWrite_EX,
  input  logic [1:0]        Size_EX,
  input  logic              Unsigned_EX,
  input  logic              MemtoReg_EX,
  input  logic              RegWrite_EX,
  input  logic [4:0]        WriteAddr_EX,
  input  logic [31:0]       ALU_Result,
  input  logic [31:0]       Mem_Store,
  output logic [4:0]        WriteAddr_WB,
  output logic              RegWrite_Mem,
  output logic              MemtoReg_WB,
  output logic [31:0]       ALU_Result_Mem,
  output logic [31:0]       WRBACK_Reg,
  output logic              Misalign_WB
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [ADDR_W-1:0] wordIdx;
  logic [1:0]        ofs;
  logic [1:0]        sizeEff;
  logic [1:0]        alignedOfs;
  logic              misaligned;
  logic              misalignedAccess;
  logic              loadValid;
  logic              storeValid;
  logic [3:0]        byteEn;
  logic [31:0]       storeData;
  logic [31:0]       rawData;

  logic [1:0]        sizeReg;
  logic              unsignedReg;
  logic [1:0]        ofsReg;
  logic              readReg;

  assign wordIdx = ALU_Result[ADDR_W+1:2];
  assign ofs     = ALU_Result[1:0];
  // Reserved size encoding is treated as a full word everywhere downstream.
  assign sizeEff = (Size_EX == 2'b11) ? 2'b10 : Size_EX;

`ifdef DMEM_MISALIGN_TRAP_EN
  assign misaligned = ((sizeEff == 2'b01) && ofs[0]) || ((sizeEff == 2'b10) && (ofs != 2'b00));
  assign alignedOfs = ofs;
`else
  assign misaligned = 1'b0;
  assign alignedOfs = (sizeEff == 2'b00) ? ofs :
                      (sizeEff == 2'b01) ? {ofs[1], 1'b0} : 2'b00;
`endif

  assign misalignedAccess = misaligned && (MemRead_EX || MemWrite_EX);
  assign loadValid        = MemRead_EX && !MemWrite_EX && !misaligned;
  assign storeValid       = MemWrite_EX && !misaligned && !Stall && !Reset;

  always_comb begin
    byteEn    = 4'b0000;
    storeData = Mem_Store;
    case (sizeEff)
      2'b00: begin
        byteEn    = 4'b0001 << alignedOfs;
        storeData = {4{Mem_Store[7:0]}};
      end
      2'b01: begin
        byteEn    = alignedOfs[1] ? 4'b1100 : 4'b0011;
        storeData = {2{Mem_Store[15:0]}};
      end
      default: byteEn = 4'b1111;
    endcase
  end

  // One independent byte-wide array per lane keeps write enables simple for RAM inference.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : genLane
      logic [7:0] laneMem [DEPTH];
      logic [7:0] laneRawReg;

      always_ff @(posedge Clock) begin
        if (storeValid && byteEn[gi]) begin
          laneMem[wordIdx] <= storeData[gi*8 +: 8];
        end
      end

      always_ff @(posedge Clock) begin
        if (Reset) begin
          laneRawReg <= 8'h00;
        end else if (!Stall) begin
          laneRawReg <= laneMem[wordIdx];
        end
      end

      assign rawData[gi*8 +: 8] = laneRawReg;
    end
  endgenerate

  always_ff @(posedge Clock) begin
    if (Reset) begin
      WriteAddr_WB   <= 5'd0;
      RegWrite_Mem   <= 1'b0;
      MemtoReg_WB    <= 1'b0;
      ALU_Result_Mem <= 32'd0;
      sizeReg        <= 2'b00;
      unsignedReg    <= 1'b0;
      ofsReg         <= 2'b00;
      readReg        <= 1'b0;
    end else if (!Stall) begin
      WriteAddr_WB   <= WriteAddr_EX;
      RegWrite_Mem   <= RegWrite_EX && !misalignedAccess;
      MemtoReg_WB    <= MemtoReg_EX;
      ALU_Result_Mem <= ALU_Result;
      sizeReg        <= sizeEff;
      unsignedReg    <= Unsigned_EX;
      ofsReg         <= alignedOfs;
      readReg        <= loadValid;
    end
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  always_ff @(posedge Clock) begin
    if (Reset) begin
      Misalign_WB <= 1'b0;
    end else if (!Stall) begin
      Misalign_WB <= misalignedAccess;
    end
  end
`else
  assign Misalign_WB = 1'b0;
`endif

  logic [7:0]  loadByte;
  logic [15:0] loadHalf;

  always_comb begin
    case (ofsReg)
      2'b00:   loadByte = rawData[7:0];
      2'b01:   loadByte = rawData[15:8];
      2'b10:   loadByte = rawData[23:16];
      default: loadByte = rawData[31:24];
    endcase
    loadHalf = ofsReg[1] ? rawData[31:16] : rawData[15:0];
    WRBACK_Reg = 32'd0;
    if (readReg) begin
      case (sizeReg)
        2'b00:   WRBACK_Reg = {{24{!unsignedReg && loadByte[7]}}, loadByte};
        2'b01:   WRBACK_Reg = {{16{!unsignedReg && loadHalf[15]}}, loadHalf};
        default: WRBACK_Reg = rawData;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_stage.sv
// Directed bench for data_mem_stage: vector table plus stall, reset and misalignment sequences.
module tb_data_mem_stage;

  logic        Clock = 1'b0;
  logic        Reset, Stall, MemRead_EX, MemWrite_EX, Unsigned_EX, MemtoReg_EX, RegWrite_EX;
  logic [1:0]  Size_EX;
  logic [4:0]  WriteAddr_EX;
  logic [31:0] ALU_Result, Mem_Store;
  logic [4:0]  WriteAddr_WB;
  logic        RegWrite_Mem, MemtoReg_WB, Misalign_WB;
  logic [31:0] ALU_Result_Mem, WRBACK_Reg;

  int checks = 0;
  int failures = 0;

  always #5 Clock = ~Clock;

  data_mem_stage #(.ADDR_W(8)) dut (
    .Clock(Clock), .Reset(Reset), .Stall(Stall),
    .MemRead_EX(MemRead_EX), .MemWrite_EX(MemWrite_EX), .Size_EX(Size_EX),
    .Unsigned_EX(Unsigned_EX), .MemtoReg_EX(MemtoReg_EX), .RegWrite_EX(RegWrite_EX),
    .WriteAddr_EX(WriteAddr_EX), .ALU_Result(ALU_Result), .Mem_Store(Mem_Store),
    .WriteAddr_WB(WriteAddr_WB), .RegWrite_Mem(RegWrite_Mem), .MemtoReg_WB(MemtoReg_WB),
    .ALU_Result_Mem(ALU_Result_Mem), .WRBACK_Reg(WRBACK_Reg), .Misalign_WB(Misalign_WB)
  );

  typedef struct {
    string       name;
    logic        rd, wr;
    logic [1:0]  size;
    logic        uns, m2r, rw;
    logic [4:0]  wa;
    logic [31:0] alu, st;
    logic [31:0] eWb;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input string n, input logic rd, input logic wr, input logic [1:0] size,
                        input logic uns, input logic m2r, input logic rw, input logic [4:0] wa,
                        input logic [31:0] alu, input logic [31:0] st, input logic [31:0] eWb);
    vec_t v;
    v.name = n; v.rd = rd; v.wr = wr; v.size = size; v.uns = uns; v.m2r = m2r;
    v.rw = rw; v.wa = wa; v.alu = alu; v.st = st; v.eWb = eWb;
    vecs.push_back(v);
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic drive(input logic stall, input logic rst, input logic rd, input logic wr,
                       input logic [1:0] size, input logic uns, input logic m2r, input logic rw,
                       input logic [4:0] wa, input logic [31:0] alu, input logic [31:0] st);
    Stall = stall; Reset = rst; MemRead_EX = rd; MemWrite_EX = wr; Size_EX = size;
    Unsigned_EX = uns; MemtoReg_EX = m2r; RegWrite_EX = rw; WriteAddr_EX = wa;
    ALU_Result = alu; Mem_Store = st;
    @(posedge Clock);
    #1;
  endtask

  task automatic expectOut(input string n, input logic [4:0] eWa, input logic eRw, input logic eM2r,
                           input logic [31:0] eAlu, input logic [31:0] eWb, input logic eMis);
    chk({n, ".wa"},  {27'd0, WriteAddr_WB}, {27'd0, eWa});
    chk({n, ".rw"},  {31'd0, RegWrite_Mem}, {31'd0, eRw});
    chk({n, ".m2r"}, {31'd0, MemtoReg_WB},  {31'd0, eM2r});
    chk({n, ".alu"}, ALU_Result_Mem, eAlu);
    chk({n, ".wb"},  WRBACK_Reg, eWb);
    chk({n, ".mis"}, {31'd0, Misalign_WB},  {31'd0, eMis});
    $display("txn %-10s wa=%0d rw=%0b m2r=%0b alu=%h wb=%h mis=%0b", n, WriteAddr_WB,
             RegWrite_Mem, MemtoReg_WB, ALU_Result_Mem, WRBACK_Reg, Misalign_WB);
  endtask

  initial begin
    //      name         rd wr size uns m2r rw wa  alu          st            expected WRBACK
    addVec("st_w_10",    0, 1, 2'd2, 0, 0, 0, 0, 32'h10,  32'hDEADBEEF, 32'h0);
    addVec("ld_w_10",    1, 0, 2'd2, 0, 1, 1, 5, 32'h10,  32'h0,        32'hDEADBEEF);
    addVec("st_b_13",    0, 1, 2'd0, 0, 0, 0, 0, 32'h13,  32'h12345680, 32'h0);
    addVec("ld_b_13s",   1, 0, 2'd0, 0, 1, 1, 6, 32'h13,  32'h0,        32'hFFFFFF80);
    addVec("ld_b_13u",   1, 0, 2'd0, 1, 1, 1, 6, 32'h13,  32'h0,        32'h00000080);
    addVec("ld_w_10b",   1, 0, 2'd2, 0, 1, 1, 7, 32'h10,  32'h0,        32'h80ADBEEF);
    addVec("st_w_20",    0, 1, 2'd2, 0, 0, 0, 0, 32'h20,  32'hAAAAAAAA, 32'h0);
    addVec("st_h_22",    0, 1, 2'd1, 0, 0, 0, 0, 32'h22,  32'hFFFF1234, 32'h0);
    addVec("ld_w_20",    1, 0, 2'd2, 0, 1, 1, 8, 32'h20,  32'h0,        32'h1234AAAA);
    addVec("ld_h_22u",   1, 0, 2'd1, 1, 1, 1, 8, 32'h22,  32'h0,        32'h00001234);
    addVec("st_h_20",    0, 1, 2'd1, 0, 0, 0, 0, 32'h20,  32'h00008001, 32'h0);
    addVec("ld_h_20s",   1, 0, 2'd1, 0, 1, 1, 9, 32'h20,  32'h0,        32'hFFFF8001);
    addVec("ld_h_20u",   1, 0, 2'd1, 1, 1, 1, 9, 32'h20,  32'h0,        32'h00008001);
    addVec("ld_b_21s",   1, 0, 2'd0, 0, 1, 1, 9, 32'h21,  32'h0,        32'hFFFFFF80);
    addVec("ld_b_22s",   1, 0, 2'd0, 0, 1, 1, 9, 32'h22,  32'h0,        32'h00000034);
    addVec("ld_b_23u",   1, 0, 2'd0, 1, 1, 1, 9, 32'h23,  32'h0,        32'h00000012);
    addVec("ld_sz3_20",  1, 0, 2'd3, 0, 1, 1, 10, 32'h20, 32'h0,        32'h12348001);
    addVec("rdwr_30",    1, 1, 2'd2, 0, 1, 1, 11, 32'h30, 32'h55667788, 32'h0);
    addVec("ld_w_30",    1, 0, 2'd2, 0, 1, 1, 11, 32'h30, 32'h0,        32'h55667788);
    addVec("ld_wrap",    1, 0, 2'd2, 0, 1, 1, 12, 32'h410, 32'h0,       32'h80ADBEEF);
    addVec("st_w_40",    0, 1, 2'd2, 0, 0, 0, 0, 32'h40,  32'h99998888, 32'h0);
    addVec("nold_40",    0, 0, 2'd2, 0, 0, 1, 13, 32'h40, 32'h0,        32'h0);

    drive(0, 1, 0, 0, 2'd0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
    expectOut("reset", 5'd0, 0, 0, 32'h0, 32'h0, 0);

    foreach (vecs[i]) begin
      drive(0, 0, vecs[i].rd, vecs[i].wr, vecs[i].size, vecs[i].uns, vecs[i].m2r, vecs[i].rw,
            vecs[i].wa, vecs[i].alu, vecs[i].st);
      expectOut(vecs[i].name, vecs[i].wa, vecs[i].rw, vecs[i].m2r, vecs[i].alu, vecs[i].eWb, 0);
    end

    // Stall with a pending store: outputs frozen, then a load proves memory untouched.
    drive(0, 0, 1, 0, 2'd2, 0, 1, 1, 5'd7, 32'h10, 32'h0);
    expectOut("stl_pre", 5'd7, 1, 1, 32'h10, 32'h80ADBEEF, 0);
    for (int c = 0; c < 3; c++) begin
      drive(1, 0, 0, 1, 2'd2, 0, 0, 0, 5'd9, 32'h40, 32'h11112222);
      expectOut("stl_hold1", 5'd7, 1, 1, 32'h10, 32'h80ADBEEF, 0);
    end
    drive(0, 0, 1, 0, 2'd2, 0, 0, 1, 5'd8, 32'h40, 32'h0);
    expectOut("stl_nowr", 5'd8, 1, 0, 32'h40, 32'h99998888, 0);
    for (int c = 0; c < 3; c++) begin
      drive(1, 0, 0, 1, 2'd2, 0, 0, 0, 5'd9, 32'h40, 32'h11112222);
      expectOut("stl_hold2", 5'd8, 1, 0, 32'h40, 32'h99998888, 0);
    end
    drive(0, 0, 0, 1, 2'd2, 0, 0, 0, 5'd9, 32'h40, 32'h11112222);
    expectOut("stl_rel", 5'd9, 0, 0, 32'h40, 32'h0, 0);
    drive(0, 0, 1, 0, 2'd2, 0, 1, 1, 5'd9, 32'h40, 32'h0);
    expectOut("stl_rdbk", 5'd9, 1, 1, 32'h40, 32'h11112222, 0);

    // Reset (with Stall also high) in a store cycle after a captured load.
    drive(0, 0, 1, 0, 2'd2, 0, 1, 1, 5'd4, 32'h10, 32'h0);
    expectOut("rst_pre", 5'd4, 1, 1, 32'h10, 32'h80ADBEEF, 0);
    drive(1, 1, 0, 1, 2'd2, 0, 1, 1, 5'd4, 32'h10, 32'hCAFEF00D);
    expectOut("rst_st", 5'd0, 0, 0, 32'h0, 32'h0, 0);
    drive(0, 0, 1, 0, 2'd2, 0, 1, 1, 5'd4, 32'h10, 32'h0);
    expectOut("rst_rdbk", 5'd4, 1, 1, 32'h10, 32'h80ADBEEF, 0);

    // Misaligned word/halfword loads and a misaligned word store.
    drive(0, 0, 1, 0, 2'd2, 0, 1, 1, 5'd3, 32'h11, 32'h0);
`ifdef DMEM_MISALIGN_TRAP_EN
    expectOut("mis_ld_w", 5'd3, 0, 1, 32'h11, 32'h0, 1);
`else
    expectOut("mis_ld_w", 5'd3, 1, 1, 32'h11, 32'h80ADBEEF, 0);
`endif
    drive(0, 0, 1, 0, 2'd1, 0, 1, 1, 5'd3, 32'h21, 32'h0);
`ifdef DMEM_MISALIGN_TRAP_EN
    expectOut("mis_ld_h", 5'd3, 0, 1, 32'h21, 32'h0, 1);
`else
    expectOut("mis_ld_h", 5'd3, 1, 1, 32'h21, 32'hFFFF8001, 0);
`endif
    drive(0, 0, 0, 1, 2'd2, 0, 0, 0, 5'd0, 32'h12, 32'h0BADBAD0);
`ifdef DMEM_MISALIGN_TRAP_EN
    expectOut("mis_st_w", 5'd0, 0, 0, 32'h12, 32'h0, 1);
`else
    expectOut("mis_st_w", 5'd0, 0, 0, 32'h12, 32'h0, 0);
`endif
    drive(0, 0, 1, 0, 2'd2, 0, 1, 1, 5'd2, 32'h10, 32'h0);
`ifdef DMEM_MISALIGN_TRAP_EN
    expectOut("mis_rdbk", 5'd2, 1, 1, 32'h10, 32'h80ADBEEF, 0);
`else
    expectOut("mis_rdbk", 5'd2, 1, 1, 32'h10, 32'h0BADBAD0, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_mem_stage.md
DATA_MEM_STAGE -- requirements
Module: data_mem_stage

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning word-address bits (depth = 2**ADDR_W 32-bit words).
REQ-002 The block SHALL have ports as follows:
- Clock  in  1  sole clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high reset
- Stall  in  1  freeze MEM/WB registers; suppress memory write
- MemRead_EX  in  1  load request
- MemWrite_EX  in  1  store request
- Size_EX  in  2  access size: 00 byte, 01 halfword, 10 word, 11 reserved
- Unsigned_EX  in  1  zero-extend loads (1) or sign-extend loads (0)
- MemtoReg_EX  in  1  writeback source select
- RegWrite_EX  in  1  register-file write enable
- WriteAddr_EX  in  5  destination register
- ALU_Result  in  32  byte address / ALU result
- Mem_Store  in  32  store data, right-aligned
- WriteAddr_WB  out  5  registered destination
- RegWrite_Mem  out  1  registered write enable
- MemtoReg_WB  out  1  registered writeback select
- ALU_Result_Mem  out  32  registered ALU result
- WRBACK_Reg  out  32  extended load data
- Misalign_WB  out  1  registered misalignment flag

Function
REQ-003 Word index SHALL be ALU_Result[ADDR_W+1:2]; byte offset ofs = ALU_Result[1:0]; higher address bits ignored, so the address wraps modulo depth.
REQ-004 The memory array SHALL be 2**ADDR_W x 32 with per-byte write enables, written on the rising edge when MemWrite_EX=1, Stall=0, Reset=0 and the access is not suppressed.
REQ-005 Store lanes SHALL be set as follows: byte writes Mem_Store[7:0] into lane ofs; halfword writes Mem_Store[15:0] into lanes {ofs[1],1}:{ofs[1],0}; word writes all four lanes. Unselected lanes SHALL remain unchanged.
REQ-006 A load SHALL read the addressed word synchronously at the rising edge of its MEM cycle into a raw-data register, together with the registered Size, Unsigned and ofs.
REQ-007 WRBACK_Reg SHALL be a combinational function of those registered values, valid in the cycle after the load, i.e. 1-cycle latency, same cycle as the other *_WB/*_Mem outputs:
- byte: lane ofs, extended per Unsigned.
- halfword: half ofs[1], extended per Unsigned.
- word: raw word.
REQ-008 Size_EX=11 SHALL behave as word.
REQ-009 If MemRead_EX=0 in the captured cycle, WRBACK_Reg SHALL be 0.
REQ-010 If MemRead_EX and MemWrite_EX are both 1, the store SHALL be performed and the load treated as absent (WRBACK_Reg=0).
REQ-011 A load issued in the cycle after a store to the same word SHALL return the post-store data; no same-cycle forwarding is required.
REQ-012 When Stall=1, all MEM/WB registers, including the raw-data register, SHALL hold their values, and no memory write SHALL occur.
REQ-013 ALU_Result_Mem, MemtoReg_WB, RegWrite_Mem and WriteAddr_WB SHALL capture their EX inputs each non-stalled cycle, with 1-cycle latency.

Reset
REQ-014 When Reset=1 at a rising edge, the following SHALL be 0 after that edge: WriteAddr_WB, RegWrite_Mem, MemtoReg_WB, ALU_Result_Mem, Misalign_WB, the raw-data register and the registered Size/Unsigned/ofs/read flag. WRBACK_Reg therefore SHALL read 0.
REQ-015 Reset SHALL take priority over Stall, and a store presented in a Reset cycle SHALL NOT be written.
REQ-016 Memory array contents SHALL NOT be affected by Reset.

Configuration
REQ-017 With macro DMEM_MISALIGN_TRAP_EN defined, a misaligned access SHALL be suppressed:
- Misaligned means a halfword with ofs[0]=1, or a word with ofs!=0.
- A misaligned store SHALL perform no write.
- A misaligned load SHALL give WRBACK_Reg=0.
- The access SHALL set Misalign_WB=1 for one non-stalled cycle.
- RegWrite_Mem SHALL be forced to 0 for that access.
REQ-018 Without DMEM_MISALIGN_TRAP_EN, ofs bits below the access size SHALL be ignored: the access is forced aligned, for example a word at ofs=3 uses ofs=0. Misalign_WB SHALL be tied 0.

Verification
REQ-019 The bench SHALL cover the following directed scenarios:
- Word store 0xDEADBEEF at address 0x10, then word load at 0x10 with MemtoReg_EX=1, RegWrite_EX=1, WriteAddr_EX=5 -> next cycle WRBACK_Reg=0xDEADBEEF, WriteAddr_WB=5.
- Byte store 0x80 at 0x13, then byte load at 0x13 with Unsigned=0 -> 0xFFFFFF80; with Unsigned=1 -> 0x00000080; word at 0x10 -> 0x80ADBEEF.
- Halfword store 0x1234 at 0x22 over word 0xAAAAAAAA -> word load 0x1234AAAA; signed halfword load of 0x8001 -> 0xFFFF8001.
- Stall=1 held 3 cycles with MemWrite_EX=1 -> outputs frozen and memory unchanged; release -> pipeline resumes and the write occurs once.
- Reset=1 asserted in a store cycle, after a load has been captured -> all outputs 0 next cycle and the target word is unchanged on readback.
- Word load at 0x11 with DMEM_MISALIGN_TRAP_EN defined -> Misalign_WB=1, RegWrite_Mem=0, WRBACK_Reg=0.
- Word load at 0x11 without DMEM_MISALIGN_TRAP_EN -> returns the word at 0x10, Misalign_WB=0.
